fifo8_word16: RTL and testbench
===============================

// Module: fifo8_word16
// PURPOSE
//  8-entry x 16-bit synchronous FIFO with valid/ready handshake on both sides.
//  Storage is eight 16-bit registers. The read word is selected by the 3-bit
//  read pointer through an 8-way 16-bit mux, so this block feeds the mux stage.
//  Sits between a word producer (ALU/IO) and a consumer that drains one word per cycle.
// PARAMETERS
//  WIDTH  16  data word width; the read mux is 16 bits wide, so only 16 is supported
//  DEPTH  8   entries; fixed at 8 to match the 3-bit mux select; pointers are 4 bits (3 + wrap bit)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_data    in   16     write word
//  in_valid   in   1      producer offers in_data
//  in_ready   out  1      FIFO accepts this cycle (= !full)
//  out_data   out  16     head word (show-ahead, combinational from storage)
//  out_valid  out  1      head word valid (= !empty)
//  out_ready  in   1      consumer takes head this cycle
//  full       out  1      8 words stored
//  empty      out  1      0 words stored
//  count      out  4      occupancy 0..8 (present only with FIFO_COUNT_EN)
// BEHAVIOUR
//  - Push happens when in_valid && in_ready: mem[wr_ptr[2:0]] <= in_data; wr_ptr += 1.
//  - Pop happens when out_valid && out_ready: rd_ptr += 1.
//  - Pointers are 4 bits and wrap 15 -> 0 naturally. Entry index uses bits [2:0].
//  - empty = (wr_ptr == rd_ptr).
//  - full  = (wr_ptr[3] != rd_ptr[3]) && (wr_ptr[2:0] == rd_ptr[2:0]).
//  - out_data = mem[rd_ptr[2:0]] through the 8-way mux (sel = rd_ptr[2:0]).
//    Latency from a push into an empty FIFO to out_valid is 1 clock.
//  - out_data is don't-care while empty. The bench must not check it then.
//  - Simultaneous push and pop (not full, not empty): both occur; occupancy is unchanged.
//  - Full: in_ready = 0, so a push is refused even if a pop occurs in the same cycle.
//    There is no pass-through. in_ready rises in the cycle after the pop.
//  - Empty: out_valid = 0, so out_ready is ignored. A push in the same cycle is
//    visible on the next cycle. There is no bypass.
//  - A producer holding in_valid while in_ready = 0 keeps in_data stable (protocol rule).
//    The FIFO does not latch refused data.
//  - Reset, async and at any time including mid-burst:
//    wr_ptr = rd_ptr = 0, all mem words = 16'h0000.
//    Outputs: empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0, count = 0.
//    Contents are discarded. The first push after reset release lands in entry 0.
//  - Control is a 2-pointer counter scheme. The derived status states
//    EMPTY / PARTIAL / FULL are not stored as separate state.
// CONFIGURATION
//  FIFO_COUNT_EN defined:
//   - The count output exists. count = wr_ptr - rd_ptr (4-bit modular), range 0..8.
//   - count is combinational from the pointers and updates on the clock after each push/pop.
//  FIFO_COUNT_EN undefined:
//   - The count port and its logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package/header `fifo8_defs.vh` holds:
//    FIFO_W = 16, FIFO_AW = 3, FIFO_PW = 4, and the reset word 16'h0000.
//  - One natural sub-module: the read select, built from the team's existing
//    8-way 16-bit mux instance (8 words in, sel = rd_ptr[2:0]).
//  - Write decode (3->8 enable), pointer registers and flag logic stay in this module.
// TESTING
//  1. Reset then idle:
//     empty=1, full=0, in_ready=1, out_valid=0, count=0.
//  2. Push 16'h0001..16'h0008 on 8 consecutive cycles with out_ready=0:
//     full=1 and in_ready=0 after the 8th push, count=8.
//     A 9th push of 16'hDEAD is refused.
//  3. From full, drain with out_ready=1:
//     out_data reads 0001..0008 in order, then empty=1 and out_valid=0.
//  4. Wrap: push 5, pop 5, then push 16'hA000..16'hA007 and pop all.
//     Order is preserved across the pointer wrap (entries 5,6,7,0,1...).
//  5. Simultaneous push+pop at count=3 for 10 cycles:
//     count stays 3 and the data order is intact. At full with push+pop,
//     only the pop occurs and count = 7.
//  6. Assert reset mid-burst with count=4:
//     flags return to reset values immediately (async).
//     After release, a push of 16'h1234 appears on out_data one cycle later.

Source files
------------

// File: rtl/fifo8_word16_pkg.sv
// Shared constants and types for the 8-entry x 16-bit FIFO.
// Optional feature macro: FIFO_COUNT_EN (adds the occupancy count output).
package fifo8_word16_pkg;

    localparam int FIFO_W     = 16;          // data word width (read mux is 16 bits)
    localparam int FIFO_AW    = 3;           // entry index width (mux select)
    localparam int FIFO_PW    = 4;           // pointer width: index + wrap bit
    localparam int FIFO_DEPTH = 1 << FIFO_AW;

    typedef logic [FIFO_W-1:0]  word_t;
    typedef logic [FIFO_AW-1:0] idx_t;
    typedef logic [FIFO_PW-1:0] ptr_t;

    localparam word_t FIFO_RESET_WORD = 16'h0000;

    // Storage entry addressed by a pointer.
    function automatic idx_t ptr_idx(input ptr_t p);
        return p[FIFO_AW-1:0];
    endfunction

    // Lap bit that tells a full FIFO apart from an empty one.
    function automatic logic ptr_wrap(input ptr_t p);
        return p[FIFO_PW-1];
    endfunction

endpackage

// File: rtl/fifo8_word16_if.sv
// Valid/ready bus between a word producer, the FIFO and its consumer.
// Optional feature macro: FIFO_COUNT_EN (adds the count signal).
interface fifo8_word16_if;
    import fifo8_word16_pkg::*;

    word_t  in_data;
    logic   in_valid;
    logic   in_ready;
    word_t  out_data;
    logic   out_valid;
    logic   out_ready;
    logic   full;
    logic   empty;
`ifdef FIFO_COUNT_EN
    ptr_t   count;
`endif

    // FIFO side.
    modport slave (
        input  in_data, in_valid, out_ready,
`ifdef FIFO_COUNT_EN
        output count,
`endif
        output in_ready, out_data, out_valid, full, empty
    );

    // Producer/consumer side.
    modport master (
        output in_data, in_valid, out_ready,
`ifdef FIFO_COUNT_EN
        input  count,
`endif
        input  in_ready, out_data, out_valid, full, empty
    );

endinterface

// File: rtl/fifo8_word16_mux.sv
// 8-way 16-bit read select: returns the storage word chosen by sel.
module fifo8_word16_mux
    import fifo8_word16_pkg::*;
(
    input  word_t words [FIFO_DEPTH],
    input  idx_t  sel,
    output word_t y
);

    // Pure combinational select of one stored word.
    always_comb begin
        y = words[sel];
    end

endmodule

// File: rtl/fifo8_word16.sv
// 8-entry x 16-bit synchronous show-ahead FIFO with valid/ready on both sides.
// Two 4-bit pointers (3-bit index + wrap bit); status flags are derived from
// the pointers, never stored. Head word comes from storage via an 8-way mux.
// Optional feature macro: FIFO_COUNT_EN (exposes occupancy 0..8 on count).
module fifo8_word16
    import fifo8_word16_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    fifo8_word16_if.slave bus
);

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    word_t                 mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_en;
    logic                  full_w;
    logic                  empty_w;
    logic                  push;
    logic                  pop;

    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (ptr_wrap(wr_ptr) != ptr_wrap(rd_ptr)) &&
                     (ptr_idx(wr_ptr) == ptr_idx(rd_ptr));

    // A full FIFO refuses writes even when a pop lands in the same cycle.
    assign push = bus.in_valid  && !full_w;
    assign pop  = bus.out_ready && !empty_w;

    // 3->8 write-enable decode for the entry under the write pointer.
    always_comb begin
        // NOTE: default first so every path assigns wr_en and no latch is inferred.
        wr_en = '0;
        if (push) begin
            wr_en[ptr_idx(wr_ptr)] = 1'b1;
        end
    end

    // Pointer registers; 4-bit wrap from 15 to 0 is natural.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;
        end
    end

    // Storage words; written only on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: storage is reset on purpose so out_data is a known zero after reset.
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= FIFO_RESET_WORD;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_en[i]) mem[i] <= bus.in_data;
            end
        end
    end

    fifo8_word16_mux u_rd_mux (
        .words (mem),
        .sel   (ptr_idx(rd_ptr)),
        .y     (bus.out_data)
    );

    assign bus.in_ready  = !full_w;
    assign bus.out_valid = !empty_w;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
`ifdef FIFO_COUNT_EN
    assign bus.count     = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_fifo8_word16.sv
// Self-checking bench for fifo8_word16: directed vectors, a scoreboard queue
// filled by the driver and a separate monitor that checks every popped word.
// Optional feature macro: FIFO_COUNT_EN (enables count checks).
module tb_fifo8_word16;
    import fifo8_word16_pkg::*;

    logic clk;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   model_cnt   = 0;
    word_t exp_q [$];

    fifo8_word16_if bus ();

    fifo8_word16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Flags expected from the bench's own occupancy model.
    task automatic check_flags(input string name);
        check({name, ".empty"},     32'(bus.empty),     32'(model_cnt == 0));
        check({name, ".full"},      32'(bus.full),      32'(model_cnt == 8));
        check({name, ".in_ready"},  32'(bus.in_ready),  32'(model_cnt != 8));
        check({name, ".out_valid"}, 32'(bus.out_valid), 32'(model_cnt != 0));
`ifdef FIFO_COUNT_EN
        check({name, ".count"},     32'(bus.count),     32'(model_cnt));
`endif
    endtask

    // One clock of stimulus; inputs change #1 after the rising edge.
    task automatic cycle(input logic v, input word_t d, input logic r);
        logic push_ok;
        logic pop_ok;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        push_ok = v && (model_cnt < 8);
        pop_ok  = r && (model_cnt > 0);
        if (push_ok) exp_q.push_back(d);
        @(posedge clk);
        #1;
        model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Monitor: every word the consumer takes must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got %h expected no word", bus.out_data);
            end else begin
                check("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // 1. Reset state and idle.
        check("rst.empty",     32'(bus.empty),     32'd1);
        check("rst.full",      32'(bus.full),      32'd0);
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
`ifdef FIFO_COUNT_EN
        check("rst.count",     32'(bus.count),     32'd0);
`endif
        reset = 1'b0;
        cycle(1'b0, '0, 1'b0);
        check_flags("idle");

        // 2. Fill with 0001..0008, then a refused 9th push.
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, word_t'(i), 1'b0);
            check_flags("fill");
        end
        check("t2.full",     32'(bus.full),     32'd1);
        check("t2.in_ready", 32'(bus.in_ready), 32'd0);
`ifdef FIFO_COUNT_EN
        check("t2.count",    32'(bus.count),    32'd8);
`endif
        cycle(1'b1, 16'hDEAD, 1'b0);
        check("t2.refused_full", 32'(bus.full), 32'd1);
        check_flags("refuse");

        // 3. Drain in order.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            check_flags("drain");
        end
        check("t3.empty",     32'(bus.empty),     32'd1);
        check("t3.out_valid", 32'(bus.out_valid), 32'd0);

        // 4. Pointer wrap: 5 in/out, then A000..A007 across entries 5,6,7,0..
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'hC000 + word_t'(i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'hA000 + word_t'(i), 1'b0);
        check("t4.full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        check("t4.empty", 32'(bus.empty), 32'd1);

        // 5. Push+pop at occupancy 3, then at full only the pop happens.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hB000 + word_t'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'hB003 + word_t'(i), 1'b1);
            check_flags("steady3");
        end
`ifdef FIFO_COUNT_EN
        check("t5.count3", 32'(bus.count), 32'd3);
`endif
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'hB100 + word_t'(i), 1'b0);
        check("t5.full", 32'(bus.full), 32'd1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        check("t5.full_after_pop",     32'(bus.full),     32'd0);
        check("t5.in_ready_after_pop", 32'(bus.in_ready), 32'd1);
`ifdef FIFO_COUNT_EN
        check("t5.count7", 32'(bus.count), 32'd7);
`endif
        check_flags("pop_at_full");
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1);
        check("t5.empty", 32'(bus.empty), 32'd1);

        // 6. Asynchronous reset mid-burst with 4 words stored.
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'hD000 + word_t'(i), 1'b0);
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("t6.empty",     32'(bus.empty),     32'd1);
        check("t6.full",      32'(bus.full),      32'd0);
        check("t6.in_ready",  32'(bus.in_ready),  32'd1);
        check("t6.out_valid", 32'(bus.out_valid), 32'd0);
`ifdef FIFO_COUNT_EN
        check("t6.count",     32'(bus.count),     32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(1'b1, 16'h1234, 1'b0);
        check("t6.out_valid_after_push", 32'(bus.out_valid), 32'd1);
        check("t6.out_data_after_push",  32'(bus.out_data),  32'h1234);
        cycle(1'b0, '0, 1'b1);
        check_flags("post_reset");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
